// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: pops ASCII commands from the UART RX FIFO, turns them into
// one-cycle stopwatch/clock control pulses merged with local buttons, and echoes a response.
module uart_cmd_ctrl #(
    parameter bit         ECHO_EN       = 1'b1,
    parameter logic [7:0] NAK_CHAR      = 8'h3F,
    parameter logic [7:0] MODE_ERR_CHAR = 8'h21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_rdata,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_wdata,
    input  logic       stopwatch_clock_mode,
    input  logic       btn_run,
    input  logic       btn_clear,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_hour_inc,
    output logic       o_min_inc,
    output logic       o_sec_inc,
    output logic [7:0] o_err_cnt
);

    typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

    state_t     state_reg, state_next;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_uc;
    logic [7:0] resp_reg, resp_next;
    logic [7:0] err_cnt_reg, err_cnt_next;
    logic       hold_reg, hold_next;
    logic       resp_due;

    // Lane 0 = run, lane 1 = clear: the outputs shared with local buttons.
    logic [1:0] btn_vec, cmd_vec, pend_reg, pend_next, pulse_reg, pulse_next;
    // Lane 2 = hour, 1 = minute, 0 = second.
    logic [2:0] clk_cmd_vec, clk_pulse_reg;

    assign btn_vec = {btn_clear, btn_run};

    always_comb begin
        cmd_uc       = cmd_reg & 8'hDF;
        cmd_vec      = 2'b00;
        clk_cmd_vec  = 3'b000;
        resp_due     = 1'b0;
        resp_next    = resp_reg;
        err_cnt_next = err_cnt_reg;
        // CR/LF are tested on the raw byte so that '-' (0x2D) is not mistaken for CR.
        if (state_reg == DECODE && cmd_reg != 8'h0D && cmd_reg != 8'h0A) begin
            resp_due  = 1'b1;
            resp_next = stopwatch_clock_mode ? cmd_reg : MODE_ERR_CHAR;
            case (cmd_uc)
                8'h52: cmd_vec[0] = stopwatch_clock_mode;
                8'h43: cmd_vec[1] = stopwatch_clock_mode;
                8'h48, 8'h4D, 8'h53: begin
                    resp_next = stopwatch_clock_mode ? MODE_ERR_CHAR : cmd_reg;
                    clk_cmd_vec[2] = !stopwatch_clock_mode && (cmd_uc == 8'h48);
                    clk_cmd_vec[1] = !stopwatch_clock_mode && (cmd_uc == 8'h4D);
                    clk_cmd_vec[0] = !stopwatch_clock_mode && (cmd_uc == 8'h53);
                end
                default: begin
                    resp_next = NAK_CHAR;
                    if (err_cnt_reg != 8'hFF)
                        err_cnt_next = err_cnt_reg + 8'd1;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        rx_rd      = 1'b0;
        tx_wr      = 1'b0;
        tx_wdata   = 8'h00;
        hold_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // hold_reg keeps silent bytes to the same 3-cycle pop spacing as echoed ones.
                if (!rx_empty && !hold_reg) begin
                    rx_rd      = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (ECHO_EN && resp_due) begin
                    state_next = RESP;
                end else begin
                    state_next = IDLE;
                    hold_next  = 1'b1;
                end
            end
            RESP: begin
                tx_wdata = resp_reg;
                if (!tx_full) begin
                    tx_wr      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            rx_rd = 1'b0;
            tx_wr = 1'b0;
        end
    end

    // Button wins a collision; the displaced command pulse waits one cycle in pend_reg.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            assign pulse_next[gi] = btn_vec[gi] | pend_reg[gi] | cmd_vec[gi];
            assign pend_next[gi]  = (btn_vec[gi] & pend_reg[gi])
                                  | (cmd_vec[gi] & (btn_vec[gi] | pend_reg[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cmd_reg       <= 8'h00;
            resp_reg      <= 8'h00;
            err_cnt_reg   <= 8'h00;
            hold_reg      <= 1'b0;
            pend_reg      <= 2'b00;
            pulse_reg     <= 2'b00;
            clk_pulse_reg <= 3'b000;
        end else begin
            state_reg     <= state_next;
            if (rx_rd)
                cmd_reg <= rx_rdata;
            resp_reg      <= resp_next;
            err_cnt_reg   <= err_cnt_next;
            hold_reg      <= hold_next;
            pend_reg      <= pend_next;
            pulse_reg     <= pulse_next;
            clk_pulse_reg <= clk_cmd_vec;
        end
    end

    assign o_run      = pulse_reg[0];
    assign o_clear    = pulse_reg[1];
    assign o_hour_inc = clk_pulse_reg[2];
    assign o_min_inc  = clk_pulse_reg[1];
    assign o_sec_inc  = clk_pulse_reg[0];
    assign o_err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: FIFO-side models, per-cycle sampling, hand-computed expectations.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty;
    logic [7:0] rx_rdata;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_wdata;
    logic       stopwatch_clock_mode;
    logic       btn_run;
    logic       btn_clear;
    logic       o_run, o_clear, o_hour_inc, o_min_inc, o_sec_inc;
    logic [7:0] o_err_cnt;

    uart_cmd_ctrl dut (
        .clk(clk), .rst(rst),
        .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
        .stopwatch_clock_mode(stopwatch_clock_mode),
        .btn_run(btn_run), .btn_clear(btn_clear),
        .o_run(o_run), .o_clear(o_clear), .o_hour_inc(o_hour_inc),
        .o_min_inc(o_min_inc), .o_sec_inc(o_sec_inc), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       s_rd, s_wr, s_run, s_clr, s_hr, s_mn, s_sc;
    logic [7:0] s_wd, s_err;
    int n_run, n_clr, n_hr, n_mn, n_sc;
    int cyc = 0;
    int last_pop = -100;
    int min_gap;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        rx_empty = (rxq.size() == 0);
        rx_rdata = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        upd();
    endtask

    task automatic clr();
        txq.delete();
        n_run = 0; n_clr = 0; n_hr = 0; n_mn = 0; n_sc = 0;
        min_gap = 1000;
    endtask

    // Samples one cycle's settled outputs, then advances past the rising edge.
    task automatic tick();
        #1;
        s_rd = rx_rd; s_wr = tx_wr; s_wd = tx_wdata; s_err = o_err_cnt;
        s_run = o_run; s_clr = o_clear; s_hr = o_hour_inc; s_mn = o_min_inc; s_sc = o_sec_inc;
        n_run += int'(s_run); n_clr += int'(s_clr);
        n_hr += int'(s_hr); n_mn += int'(s_mn); n_sc += int'(s_sc);
        if (s_wr) txq.push_back(s_wd);
        if (s_rd) begin
            if (cyc - last_pop < min_gap) min_gap = cyc - last_pop;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
        upd();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; tx_full = 1'b0; stopwatch_clock_mode = 1'b1;
        btn_run = 1'b0; btn_clear = 1'b0;
        upd(); clr();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_pulses", {s_rd, s_wr, s_run, s_clr, s_hr, s_mn, s_sc}, 7'd0);
        chk("reset_wdata", s_wd, 8'h00);
        chk("reset_err", s_err, 8'h00);

        // Stopwatch 'R': pop, decode, pulse + echo two cycles after the pop.
        push(8'h52);
        tick(); chk("t1_pop", s_rd, 1'b1);
        tick(); chk("t1_pop_once", s_rd, 1'b0); chk("t1_run_early", s_run, 1'b0);
        tick(); chk("t1_run", s_run, 1'b1); chk("t1_wr", s_wr, 1'b1); chk("t1_wdata", s_wd, 8'h52);
        tick(); chk("t1_run_width", s_run, 1'b0); chk("t1_wr_once", s_wr, 1'b0);
        chk("t1_err", s_err, 8'h00);

        // Clock mode back-to-back: 'h','M','s',CR.
        clr(); stopwatch_clock_mode = 1'b0;
        push(8'h68); push(8'h4D); push(8'h73); push(8'h0D);
        for (int i = 0; i < 16; i++) tick();
        chk("t2_hour", n_hr, 1); chk("t2_min", n_mn, 1); chk("t2_sec", n_sc, 1);
        chk("t2_run", n_run, 0);
        chk("t2_tx_count", txq.size(), 3);
        chk("t2_tx0", txq[0], 8'h68); chk("t2_tx1", txq[1], 8'h4D); chk("t2_tx2", txq[2], 8'h73);
        chk("t2_gap_ok", min_gap >= 3, 1'b1);
        chk("t2_drained", rxq.size(), 0);

        // Wrong-mode command, then unknown bytes up to saturation.
        clr(); push(8'h52);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_no_run", n_run, 0); chk("t3_mode_err_cnt", txq.size(), 1);
        chk("t3_mode_err", txq[0], 8'h21); chk("t3_err0", o_err_cnt, 8'h00);
        clr(); push(8'h7A);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_nak_cnt", txq.size(), 1); chk("t3_nak", txq[0], 8'h3F);
        chk("t3_err1", o_err_cnt, 8'h01);
        clr();
        for (int i = 0; i < 300; i++) push((i % 2 == 0) ? 8'h7A : 8'h31);
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (rxq.size() == 0) break;
        end
        chk("t3_bulk_drained", rxq.size(), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_bulk_naks", txq.size(), 300);
        chk("t3_err_sat", o_err_cnt, 8'hFF);

        // TX backpressure for 20 cycles in RESP.
        clr(); stopwatch_clock_mode = 1'b1; tx_full = 1'b1;
        push(8'h43); push(8'h52);
        tick(); chk("t4_pop", s_rd, 1'b1);
        tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_wr || s_rd) bad++;
        end
        chk("t4_stall", bad, 0);
        chk("t4_clear", n_clr, 1);
        tx_full = 1'b0;
        tick(); chk("t4_wr", s_wr, 1'b1); chk("t4_wdata", s_wd, 8'h43); chk("t4_no_pop", s_rd, 1'b0);
        tick(); chk("t4_next_pop", s_rd, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_tx_count", txq.size(), 2); chk("t4_tx1", txq[1], 8'h52); chk("t4_run", n_run, 1);

        // Button and command pulse collide on o_run.
        clr(); push(8'h52);
        tick();
        btn_run = 1'b1;
        tick(); chk("t5_run_c1", s_run, 1'b0);
        btn_run = 1'b0;
        tick(); chk("t5_run_btn", s_run, 1'b1);
        tick(); chk("t5_run_cmd", s_run, 1'b1);
        tick(); chk("t5_run_end", s_run, 1'b0);
        chk("t5_run_total", n_run, 2);
        btn_clear = 1'b1;
        tick(); chk("t5_clr_c0", s_clr, 1'b0);
        btn_clear = 1'b0;
        tick(); chk("t5_clr_btn", s_clr, 1'b1);
        tick(); chk("t5_clr_end", s_clr, 1'b0);

        // Reset while a popped 'R' sits in DECODE.
        clr(); push(8'h52); push(8'h43);
        tick(); chk("t6_pop_r", s_rd, 1'b1);
        rst = 1'b1;
        tick(); chk("t6_no_pop_rst", s_rd, 1'b0);
        rst = 1'b0;
        tick();
        chk("t6_outs_zero", {s_wr, s_run, s_clr, s_hr, s_mn, s_sc}, 6'd0);
        chk("t6_err_zero", s_err, 8'h00);
        chk("t6_pop_c", s_rd, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_tx_count", txq.size(), 1); chk("t6_tx0", txq[0], 8'h43);
        chk("t6_clear", n_clr, 1); chk("t6_no_run", n_run, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
